// File: rtl/avm_arbit.sv
// rtl/avm_arbit.sv - two-requester Avalon-MM arbiter for the HyperRAM controller port
//
// Purpose: shares one Avalon-MM controller port between requesters s0 and s1.
// A grant is held for a whole burst: every write beat, or every returned read
// word. When both requesters ask at once, the one that did not own the last
// completed burst wins.
//
// Ports:
//   clk_i, rst_i             clock; synchronous active-high reset
//   s0_avm_* / s1_avm_*      requester ports (write, read, address[31:0],
//                            writedata[15:0], byteenable[1:0], burstcount[7:0]
//                            in; readdata[15:0], readdatavalid, waitrequest out)
//   m_avm_*                  controller port (same fields, opposite direction)

module avm_arbit (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        s0_avm_write_i,
  input  logic        s0_avm_read_i,
  input  logic [31:0] s0_avm_address_i,
  input  logic [15:0] s0_avm_writedata_i,
  input  logic [1:0]  s0_avm_byteenable_i,
  input  logic [7:0]  s0_avm_burstcount_i,
  output logic [15:0] s0_avm_readdata_o,
  output logic        s0_avm_readdatavalid_o,
  output logic        s0_avm_waitrequest_o,

  input  logic        s1_avm_write_i,
  input  logic        s1_avm_read_i,
  input  logic [31:0] s1_avm_address_i,
  input  logic [15:0] s1_avm_writedata_i,
  input  logic [1:0]  s1_avm_byteenable_i,
  input  logic [7:0]  s1_avm_burstcount_i,
  output logic [15:0] s1_avm_readdata_o,
  output logic        s1_avm_readdatavalid_o,
  output logic        s1_avm_waitrequest_o,

  output logic        m_avm_write_o,
  output logic        m_avm_read_o,
  output logic [31:0] m_avm_address_o,
  output logic [15:0] m_avm_writedata_o,
  output logic [1:0]  m_avm_byteenable_o,
  output logic [7:0]  m_avm_burstcount_o,
  input  logic [15:0] m_avm_readdata_i,
  input  logic        m_avm_readdatavalid_i,
  input  logic        m_avm_waitrequest_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVE      = 2'd1,
    WRITE_BURST = 2'd2,
    READ_WAIT   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        grant, grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic [7:0]  remaining, remaining_nxt;

  logic        s0_req, s1_req, arb_pick;
  logic        sel_write, sel_read;
  logic [7:0]  sel_burstcount;

  assign s0_req = s0_avm_write_i | s0_avm_read_i;
  assign s1_req = s1_avm_write_i | s1_avm_read_i;

  // Contention goes to whoever did not own the last completed burst.
  assign arb_pick = (s0_req && s1_req) ? ~last_grant : s1_req;

  assign sel_write      = grant ? s1_avm_write_i      : s0_avm_write_i;
  assign sel_read       = grant ? s1_avm_read_i       : s0_avm_read_i;
  assign sel_burstcount = grant ? s1_avm_burstcount_i : s0_avm_burstcount_i;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    remaining_nxt  = remaining;

    m_avm_write_o      = 1'b0;
    m_avm_read_o       = 1'b0;
    m_avm_address_o    = grant ? s1_avm_address_i    : s0_avm_address_i;
    m_avm_writedata_o  = grant ? s1_avm_writedata_i  : s0_avm_writedata_i;
    m_avm_byteenable_o = grant ? s1_avm_byteenable_i : s0_avm_byteenable_i;
    m_avm_burstcount_o = sel_burstcount;

    s0_avm_readdata_o      = m_avm_readdata_i;
    s1_avm_readdata_o      = m_avm_readdata_i;
    s0_avm_readdatavalid_o = 1'b0;
    s1_avm_readdatavalid_o = 1'b0;
    s0_avm_waitrequest_o   = 1'b1;
    s1_avm_waitrequest_o   = 1'b1;

    case (state)
      IDLE: begin
        if (s0_req || s1_req) begin
          grant_nxt = arb_pick;
          state_nxt = ACTIVE;
        end
      end

      ACTIVE: begin
        m_avm_write_o = sel_write;
        m_avm_read_o  = sel_read;
        if (grant) s1_avm_waitrequest_o = m_avm_waitrequest_i;
        else       s0_avm_waitrequest_o = m_avm_waitrequest_i;
        if (!m_avm_waitrequest_i) begin
          if (sel_read) begin
            remaining_nxt = (sel_burstcount == 8'd0) ? 8'd1 : sel_burstcount;
            state_nxt     = READ_WAIT;
          end else if (sel_write) begin
            // Burstcount 0 and 1 are both single-beat writes.
            if (sel_burstcount <= 8'd1) begin
              remaining_nxt  = 8'd0;
              state_nxt      = IDLE;
              last_grant_nxt = grant;
            end else begin
              remaining_nxt = sel_burstcount - 8'd1;
              state_nxt     = WRITE_BURST;
            end
          end
        end
      end

      WRITE_BURST: begin
        // Reads are masked so a mixed strobe cannot start a read mid-burst.
        m_avm_write_o = sel_write;
        if (grant) s1_avm_waitrequest_o = m_avm_waitrequest_i;
        else       s0_avm_waitrequest_o = m_avm_waitrequest_i;
        if (sel_write && !m_avm_waitrequest_i) begin
          remaining_nxt = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end

      READ_WAIT: begin
        if (m_avm_readdatavalid_i) begin
          if (grant) s1_avm_readdatavalid_o = 1'b1;
          else       s0_avm_readdatavalid_o = 1'b1;
          remaining_nxt = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Hold the requester-visible outputs quiet for the whole reset cycle, not
    // just from the edge after reset is seen.
    if (rst_i) begin
      m_avm_write_o          = 1'b0;
      m_avm_read_o           = 1'b0;
      s0_avm_waitrequest_o   = 1'b1;
      s1_avm_waitrequest_o   = 1'b1;
      s0_avm_readdatavalid_o = 1'b0;
      s1_avm_readdatavalid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      remaining  <= 8'd0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      remaining  <= remaining_nxt;
    end
  end

endmodule

// File: tb/tb_avm_arbit.sv
// tb/tb_avm_arbit.sv - directed self-checking bench for avm_arbit

module tb_avm_arbit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s0_avm_write_i, s0_avm_read_i;
  logic [31:0] s0_avm_address_i;
  logic [15:0] s0_avm_writedata_i;
  logic [1:0]  s0_avm_byteenable_i;
  logic [7:0]  s0_avm_burstcount_i;
  logic [15:0] s0_avm_readdata_o;
  logic        s0_avm_readdatavalid_o, s0_avm_waitrequest_o;
  logic        s1_avm_write_i, s1_avm_read_i;
  logic [31:0] s1_avm_address_i;
  logic [15:0] s1_avm_writedata_i;
  logic [1:0]  s1_avm_byteenable_i;
  logic [7:0]  s1_avm_burstcount_i;
  logic [15:0] s1_avm_readdata_o;
  logic        s1_avm_readdatavalid_o, s1_avm_waitrequest_o;
  logic        m_avm_write_o, m_avm_read_o;
  logic [31:0] m_avm_address_o;
  logic [15:0] m_avm_writedata_o;
  logic [1:0]  m_avm_byteenable_o;
  logic [7:0]  m_avm_burstcount_o;
  logic [15:0] m_avm_readdata_i;
  logic        m_avm_readdatavalid_i, m_avm_waitrequest_i;

  int vectors = 0;
  int miscompares = 0;

  avm_arbit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0_avm_write_i(s0_avm_write_i), .s0_avm_read_i(s0_avm_read_i),
    .s0_avm_address_i(s0_avm_address_i), .s0_avm_writedata_i(s0_avm_writedata_i),
    .s0_avm_byteenable_i(s0_avm_byteenable_i), .s0_avm_burstcount_i(s0_avm_burstcount_i),
    .s0_avm_readdata_o(s0_avm_readdata_o), .s0_avm_readdatavalid_o(s0_avm_readdatavalid_o),
    .s0_avm_waitrequest_o(s0_avm_waitrequest_o),
    .s1_avm_write_i(s1_avm_write_i), .s1_avm_read_i(s1_avm_read_i),
    .s1_avm_address_i(s1_avm_address_i), .s1_avm_writedata_i(s1_avm_writedata_i),
    .s1_avm_byteenable_i(s1_avm_byteenable_i), .s1_avm_burstcount_i(s1_avm_burstcount_i),
    .s1_avm_readdata_o(s1_avm_readdata_o), .s1_avm_readdatavalid_o(s1_avm_readdatavalid_o),
    .s1_avm_waitrequest_o(s1_avm_waitrequest_o),
    .m_avm_write_o(m_avm_write_o), .m_avm_read_o(m_avm_read_o),
    .m_avm_address_o(m_avm_address_o), .m_avm_writedata_o(m_avm_writedata_o),
    .m_avm_byteenable_o(m_avm_byteenable_o), .m_avm_burstcount_o(m_avm_burstcount_o),
    .m_avm_readdata_i(m_avm_readdata_i), .m_avm_readdatavalid_i(m_avm_readdatavalid_i),
    .m_avm_waitrequest_i(m_avm_waitrequest_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int beats;
    int cyc;

    rst_i = 1'b1;
    s0_avm_write_i = 0; s0_avm_read_i = 0; s0_avm_address_i = 0; s0_avm_writedata_i = 0;
    s0_avm_byteenable_i = 2'b11; s0_avm_burstcount_i = 0;
    s1_avm_write_i = 0; s1_avm_read_i = 0; s1_avm_address_i = 0; s1_avm_writedata_i = 0;
    s1_avm_byteenable_i = 2'b11; s1_avm_burstcount_i = 0;
    m_avm_readdata_i = 0; m_avm_readdatavalid_i = 0; m_avm_waitrequest_i = 0;

    // Reset state, with a stray valid and request present.
    tick(); tick();
    m_avm_readdatavalid_i = 1; s0_avm_read_i = 1;
    #2;
    check("rst_m_write", m_avm_write_o, 0);
    check("rst_m_read", m_avm_read_o, 0);
    check("rst_s0_wait", s0_avm_waitrequest_o, 1);
    check("rst_s1_wait", s1_avm_waitrequest_o, 1);
    check("rst_s0_rdv", s0_avm_readdatavalid_o, 0);
    check("rst_s1_rdv", s1_avm_readdatavalid_o, 0);

    // Both read burstcount 4 at once: s0 first, then s1.
    tick();
    rst_i = 0; m_avm_readdatavalid_i = 0;
    s0_avm_read_i = 1; s0_avm_burstcount_i = 4; s0_avm_address_i = 32'h0000_0100;
    s1_avm_read_i = 1; s1_avm_burstcount_i = 4; s1_avm_address_i = 32'h8000_0200;
    #2;
    check("rr_idle_m_read", m_avm_read_o, 0);
    check("rr_idle_s0_wait", s0_avm_waitrequest_o, 1);
    tick(); #2;
    check("rr_s0_m_read", m_avm_read_o, 1);
    check("rr_s0_addr", m_avm_address_o, 32'h0000_0100);
    check("rr_s0_bc", m_avm_burstcount_o, 4);
    check("rr_s0_wait", s0_avm_waitrequest_o, 0);
    check("rr_s0_s1_wait", s1_avm_waitrequest_o, 1);
    tick();
    s0_avm_read_i = 0;
    #2;
    check("rr_rw_gap_rdv", s0_avm_readdatavalid_o, 0);
    check("rr_rw_m_read", m_avm_read_o, 0);
    check("rr_rw_s0_wait", s0_avm_waitrequest_o, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      m_avm_readdatavalid_i = 1; m_avm_readdata_i = 16'hA000 + 16'(k);
      #2;
      check("rr_s0_rdv", s0_avm_readdatavalid_o, 1);
      check("rr_s0_rdata", s0_avm_readdata_o, 16'hA000 + 16'(k));
      check("rr_s1_rdv_quiet", s1_avm_readdatavalid_o, 0);
      check("rr_s1_wait_hold", s1_avm_waitrequest_o, 1);
    end
    tick();
    m_avm_readdatavalid_i = 0;
    #2;
    check("rr_idle2_m_read", m_avm_read_o, 0);
    check("rr_idle2_s1_wait", s1_avm_waitrequest_o, 1);
    tick();
    m_avm_waitrequest_i = 1;
    #2;
    check("rr_s1_m_read", m_avm_read_o, 1);
    check("rr_s1_addr", m_avm_address_o, 32'h8000_0200);
    check("rr_s1_stall", s1_avm_waitrequest_o, 1);
    check("rr_s1_s0_wait", s0_avm_waitrequest_o, 1);
    tick();
    m_avm_waitrequest_i = 0;
    #2;
    check("rr_s1_wait", s1_avm_waitrequest_o, 0);
    tick();
    s1_avm_read_i = 0;
    for (int k = 0; k < 4; k++) begin
      m_avm_readdatavalid_i = 1; m_avm_readdata_i = 16'hB000 + 16'(k);
      #2;
      check("rr_s1_rdv", s1_avm_readdatavalid_o, 1);
      check("rr_s1_rdata", s1_avm_readdata_o, 16'hB000 + 16'(k));
      check("rr_s0_rdv_quiet", s0_avm_readdatavalid_o, 0);
      tick();
    end
    m_avm_readdatavalid_i = 0;
    #2;
    check("rr_end_m_read", m_avm_read_o, 0);

    // s0 write burst of 8 with controller stalls; s1 waits throughout.
    tick();
    s0_avm_write_i = 1; s0_avm_burstcount_i = 8; s0_avm_address_i = 32'h0000_0400;
    s0_avm_writedata_i = 16'h1000;
    s1_avm_write_i = 1; s1_avm_burstcount_i = 1; s1_avm_address_i = 32'h0000_0500;
    #2;
    check("wr_idle_m_write", m_avm_write_o, 0);
    tick();
    beats = 0; cyc = 0;
    while (beats < 8 && cyc < 40) begin
      m_avm_waitrequest_i = (cyc % 3 == 1);
      s0_avm_writedata_i = 16'h1000 + 16'(beats);
      s0_avm_read_i = (beats >= 2);
      #2;
      check("wr_m_write", m_avm_write_o, 1);
      check("wr_m_read_masked", m_avm_read_o, 0);
      check("wr_wdata", m_avm_writedata_o, 16'h1000 + 16'(beats));
      check("wr_addr", m_avm_address_o, 32'h0000_0400);
      check("wr_s0_wait", s0_avm_waitrequest_o, m_avm_waitrequest_i);
      check("wr_s1_wait", s1_avm_waitrequest_o, 1);
      if (!m_avm_waitrequest_i) beats++;
      cyc++;
      tick();
    end
    check("wr_beats", beats, 8);
    s0_avm_write_i = 0; s0_avm_read_i = 0; s1_avm_write_i = 0; m_avm_waitrequest_i = 0;
    #2;
    check("wr_done_s0_wait", s0_avm_waitrequest_o, 1);
    check("wr_done_m_write", m_avm_write_o, 0);

    // s1 alone: three single reads, one IDLE cycle between grants.
    for (int i = 0; i < 3; i++) begin
      tick();
      m_avm_readdatavalid_i = 0;
      s1_avm_read_i = 1; s1_avm_burstcount_i = 1; s1_avm_address_i = 32'h300 + i;
      #2;
      check("sr_idle_m_read", m_avm_read_o, 0);
      check("sr_idle_s1_wait", s1_avm_waitrequest_o, 1);
      tick(); #2;
      check("sr_m_read", m_avm_read_o, 1);
      check("sr_addr", m_avm_address_o, 32'h300 + i);
      check("sr_s1_wait", s1_avm_waitrequest_o, 0);
      check("sr_s0_wait", s0_avm_waitrequest_o, 1);
      tick();
      s1_avm_read_i = 0; m_avm_readdatavalid_i = 1; m_avm_readdata_i = 16'hC000 + 16'(i);
      #2;
      check("sr_s1_rdv", s1_avm_readdatavalid_o, 1);
      check("sr_s0_rdv", s0_avm_readdatavalid_o, 0);
    end

    // Burstcount 0 read then write: one beat each.
    tick();
    m_avm_readdatavalid_i = 0;
    s0_avm_read_i = 1; s0_avm_burstcount_i = 0; s0_avm_address_i = 32'h0000_0600;
    #2;
    check("b0r_idle_m_read", m_avm_read_o, 0);
    tick(); #2;
    check("b0r_m_read", m_avm_read_o, 1);
    check("b0r_s0_wait", s0_avm_waitrequest_o, 0);
    tick();
    s0_avm_read_i = 0; m_avm_readdatavalid_i = 1; m_avm_readdata_i = 16'hD000;
    #2;
    check("b0r_s0_rdv", s0_avm_readdatavalid_o, 1);
    tick(); #2;
    check("b0r_done_rdv", s0_avm_readdatavalid_o, 0);
    tick();
    m_avm_readdatavalid_i = 0; s0_avm_write_i = 1;
    #2;
    check("b0w_idle_m_write", m_avm_write_o, 0);
    tick(); #2;
    check("b0w_m_write", m_avm_write_o, 1);
    check("b0w_s0_wait", s0_avm_waitrequest_o, 0);
    tick();
    s0_avm_write_i = 0;
    #2;
    check("b0w_done_s0_wait", s0_avm_waitrequest_o, 1);
    check("b0w_done_m_write", m_avm_write_o, 0);

    // Reset with 2 read words outstanding; then s0 wins contention.
    tick();
    s0_avm_read_i = 1; s0_avm_burstcount_i = 4; s0_avm_address_i = 32'h0000_0100;
    tick(); #2;
    check("mr_m_read", m_avm_read_o, 1);
    tick();
    s0_avm_read_i = 0; m_avm_readdatavalid_i = 1;
    #2;
    check("mr_rdv1", s0_avm_readdatavalid_o, 1);
    tick(); #2;
    check("mr_rdv2", s0_avm_readdatavalid_o, 1);
    tick();
    rst_i = 1;
    #2;
    check("mr_rst_rdv", s0_avm_readdatavalid_o, 0);
    check("mr_rst_s0_wait", s0_avm_waitrequest_o, 1);
    check("mr_rst_s1_wait", s1_avm_waitrequest_o, 1);
    tick();
    rst_i = 0;
    s0_avm_read_i = 1; s1_avm_read_i = 1;
    s1_avm_burstcount_i = 1; s1_avm_address_i = 32'h8000_0200;
    #2;
    check("mr_late_s0_rdv", s0_avm_readdatavalid_o, 0);
    check("mr_late_s1_rdv", s1_avm_readdatavalid_o, 0);
    check("mr_idle_m_read", m_avm_read_o, 0);
    tick();
    m_avm_readdatavalid_i = 0;
    #2;
    check("mr_s0_wins_wait", s0_avm_waitrequest_o, 0);
    check("mr_s1_loses_wait", s1_avm_waitrequest_o, 1);
    check("mr_s0_addr", m_avm_address_o, 32'h0000_0100);

    s0_avm_read_i = 0; s1_avm_read_i = 0; rst_i = 1;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
